fifo_ctrl: RTL and testbench

//   Write/read engine of the 8-entry FIFO: samples wr_en/rd_en, stores and returns data,
//   and maintains the registered state code and occupancy count. Drives state[2:0] and

---
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Write/read engine of the 8-entry FIFO: owns storage, pointers, occupancy and the state code.
// One-cycle registered response; no backpressure, overflow/underflow reported as error states.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            state,
    output logic [3:0]            data_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100
    } state_e;

    state_e                state_q,  state_d;
    logic [3:0]            count_q,  count_d;
    logic [2:0]            wr_ptr_q, wr_ptr_d;
    logic [2:0]            rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q,   dout_d;
    logic [DATA_WIDTH-1:0] mem_q [8];

    logic full, empty, do_wr, do_rd;

    assign full  = (count_q == 4'd8);
    assign empty = (count_q == 4'd0);
    assign do_wr = wr_en && !rd_en && !full;
    assign do_rd = rd_en && !wr_en && !empty;

    // Simultaneous or absent requests are a no-op; only a lone request acts.
    always_comb begin
        state_d  = IDLE;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_en && !rd_en) begin
            if (full) begin
                state_d = WR_ERROR;
            end else begin
                state_d  = WRITE;
                wr_ptr_d = wr_ptr_q + 3'd1;
                count_d  = count_q + 4'd1;
            end
        end else if (rd_en && !wr_en) begin
            if (empty) begin
                state_d = RD_ERROR;
            end else begin
                state_d  = READ;
                dout_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 3'd1;
                count_d  = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign state      = state_q;
    assign data_count = count_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue model predicts state/count, read data is scoreboarded.
module tb_fifo_ctrl;

    localparam int DW = 32;
    localparam logic [2:0] S_IDLE = 3'b000, S_WRITE = 3'b001, S_READ = 3'b010,
                           S_WR_ERR = 3'b011, S_RD_ERR = 3'b100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [2:0]    state;
    logic [3:0]    data_count;

    fifo_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .din        (din),
        .dout       (dout),
        .state      (state),
        .data_count (data_count)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb_q    [$];
    logic [2:0]    exp_state;
    logic [DW-1:0] exp_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one request, predict it, then check the registered response after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        if (wr && !rd) begin
            if (model_q.size() < 8) begin
                model_q.push_back(d);
                exp_state = S_WRITE;
            end else begin
                exp_state = S_WR_ERR;
            end
        end else if (rd && !wr) begin
            if (model_q.size() > 0) begin
                sb_q.push_back(model_q.pop_front());
                exp_state = S_READ;
            end else begin
                exp_state = S_RD_ERR;
            end
        end else begin
            exp_state = S_IDLE;
        end
        @(posedge clk);
        #1;
        chk({tag, "_state"}, 32'(state), 32'(exp_state));
        chk({tag, "_count"}, 32'(data_count), 32'(model_q.size()));
        if (exp_state == S_READ && sb_q.size() > 0) exp_dout = sb_q.pop_front();
        chk({tag, "_dout"}, dout, exp_dout);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        exp_dout = '0;
        #3;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_dout", dout, 32'd0);
        #4 reset_n = 1'b1;

        // Fill to full, then overflow.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i * 32'h11), "fill");
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF, "ovf");

        // Drain in order, then underflow.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "drain");
        cycle(1'b0, 1'b1, '0, "unf");
        chk("unf_hold", dout, 32'h88);

        // Simultaneous and absent requests at count 3 must not disturb anything.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h300 + DW'(i), "pre3");
        cycle(1'b1, 1'b1, 32'hBAD0_0001, "both_hi");
        cycle(1'b0, 1'b0, 32'hBAD0_0002, "both_lo");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "post3");

        // Pointer wrap.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h600 + DW'(i), "wrap_w6");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0, "wrap_r6");
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 32'hA0 + DW'(i), "wrap_w5");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, "wrap_r5");
        chk("wrap_last", dout, 32'hA5);

        // Alternating write/read, back-to-back.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) cycle(1'b1, 1'b0, $urandom, "alt_w");
            else            cycle(1'b0, 1'b1, '0, "alt_r");
        end

        // Reset mid-stream discards data without a clock edge.
        cycle(1'b1, 1'b0, 32'h1234_5678, "mid_w");
        cycle(1'b1, 1'b0, 32'h9ABC_DEF0, "mid_w");
        cycle(1'b0, 1'b1, '0, "mid_r");
        reset_n = 1'b0;
        #2;
        chk("mid_rst_state", 32'(state), 32'(S_IDLE));
        chk("mid_rst_count", 32'(data_count), 32'd0);
        chk("mid_rst_dout", dout, 32'd0);
        model_q.delete();
        sb_q.delete();
        exp_dout = '0;
        #2 reset_n = 1'b1;
        cycle(1'b0, 1'b1, '0, "post_rst_rd");
        cycle(1'b1, 1'b0, 32'h0000_00C3, "post_rst_wr");
        cycle(1'b0, 1'b1, '0, "post_rst_rd2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
